// File: rtl/uurisc_pkg.sv
// Shared definitions for the uurisc host-side loader: widths, command
// opcodes, ack flag and the loader FSM state type.
package uurisc_pkg;

   localparam int INSTR_W  = 32;
   localparam int INSTR_AW = 16;
   localparam int DATA_W   = 32;
   localparam int DATA_AW  = 16;

   localparam logic [7:0] CMD_LOAD_I = 8'h01;
   localparam logic [7:0] CMD_LOAD_D = 8'h02;
   localparam logic [7:0] CMD_RUN    = 8'h03;
   localparam logic [7:0] CMD_HALT   = 8'h04;
   localparam logic [7:0] CMD_READ_D = 8'h05;
   localparam logic [7:0] ACK_FLAG   = 8'h80;

   typedef enum logic [3:0] {
      ST_CMD,
      ST_ADDR_LO,
      ST_ADDR_HI,
      ST_CNT_LO,
      ST_CNT_HI,
      ST_PAYLOAD,
      ST_WRITE,
      ST_ACK,
      ST_RD_WAIT,
      ST_RD_LATCH,
      ST_TX,
      ST_HALT_WAIT
   } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Little-endian word assembler: shifts bytes in from the top so the first
// byte received ends up in bits [7:0] after four bytes.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart assembly (byte counter back to 0)
//   byte_valid  : byte_in is taken this cycle
//   byte_in     : incoming byte
//   word        : assembled word (complete the cycle after word_done)
//   word_done   : high in the cycle the 4th byte of a word is taken
module word_assembler
   import uurisc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word,
   output logic              word_done
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         word     <= '0;
         byte_cnt <= 2'd0;
      end else if (byte_valid) begin
         word     <= {byte_in, word[DATA_W-1:8]};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_done = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Host-side loader: decodes framed commands from the debug byte link, writes
// instruction/data memory, reads data words back and controls run.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   rx_data/valid/ready    : inbound command byte stream
//   tx_data/valid/ready    : outbound ack / read-data byte stream
//   imem_wr/addr/data      : instruction memory write port
//   data_wr/addr/din/dout  : execution unit data port (dout one cycle after addr)
//   run, busy              : run level to / activity from the execution unit
//   err                    : sticky illegal/rejected command flag
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_CMD       | waiting for a command byte
// ST_ADDR_LO   | receiving address low byte
// ST_ADDR_HI   | receiving address high byte
// ST_CNT_LO    | receiving word count low byte
// ST_CNT_HI    | receiving word count high byte
// ST_PAYLOAD   | receiving payload bytes of the current word
// ST_WRITE     | one-cycle memory write strobe, then advance address
// ST_ACK       | presenting command|0x80 until tx handshake
// ST_RD_WAIT   | data_addr driven, memory read in flight
// ST_RD_LATCH  | capture data_dout
// ST_TX        | sending the read word, LSB first
// ST_HALT_WAIT | run dropped, waiting for busy to clear
module program_loader
   import uurisc_pkg::*;
#(
   parameter int INSTR_WIDTH      = INSTR_W,
   parameter int INSTR_ADDR_WIDTH = INSTR_AW,
   parameter int DATA_WIDTH       = DATA_W,
   parameter int DATA_ADDR_WIDTH  = DATA_AW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic [7:0]                  tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic                        imem_wr,
   output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
   output logic [INSTR_WIDTH-1:0]      imem_data,
   output logic                        data_wr,
   output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
   output logic [DATA_WIDTH-1:0]       data_din,
   input  logic [DATA_WIDTH-1:0]       data_dout,
   output logic                        run,
   input  logic                        busy,
   output logic                        err
);

   loader_state_t state, state_nxt;

   logic [7:0]                 cmd_q;
   logic [DATA_ADDR_WIDTH-1:0] addr_q;
   logic [15:0]                cnt_q;
   logic [DATA_WIDTH-1:0]      rd_word_q;
   logic [1:0]                 tx_left_q;
   logic                       run_q;
   logic                       err_q;

   logic                       rx_fire;
   logic                       cmd_bad;
   logic                       asm_clear;
   logic                       asm_valid;
   logic [DATA_WIDTH-1:0]      asm_word;
   logic                       asm_done;

   // Gated by rst so nothing is accepted while reset is held.
   assign rx_ready = !rst && (state inside {ST_CMD, ST_ADDR_LO, ST_ADDR_HI,
                                            ST_CNT_LO, ST_CNT_HI, ST_PAYLOAD});
   assign rx_fire   = rx_valid && rx_ready;
   assign asm_clear = (state == ST_CMD);
   assign asm_valid = rx_fire && (state == ST_PAYLOAD);

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (asm_clear),
      .byte_valid (asm_valid),
      .byte_in    (rx_data),
      .word       (asm_word),
      .word_done  (asm_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      imem_wr   = 1'b0;
      data_wr   = 1'b0;
      cmd_bad   = 1'b0;
      case (state)
         ST_CMD: begin
            if (rx_fire) begin
               // While running only HALT is accepted.
               if (run_q && (rx_data != CMD_HALT)) begin
                  cmd_bad = 1'b1;
               end else begin
                  case (rx_data)
                     CMD_LOAD_I, CMD_LOAD_D, CMD_READ_D: state_nxt = ST_ADDR_LO;
                     CMD_RUN:                            state_nxt = ST_ACK;
                     CMD_HALT:                           state_nxt = ST_HALT_WAIT;
                     default:                            cmd_bad   = 1'b1;
                  endcase
               end
            end
         end
         ST_ADDR_LO: begin
            if (rx_fire) state_nxt = ST_ADDR_HI;
         end
         ST_ADDR_HI: begin
            if (rx_fire) state_nxt = (cmd_q == CMD_READ_D) ? ST_RD_WAIT : ST_CNT_LO;
         end
         ST_CNT_LO: begin
            if (rx_fire) state_nxt = ST_CNT_HI;
         end
         ST_CNT_HI: begin
            if (rx_fire) state_nxt = ({rx_data, cnt_q[7:0]} == 16'd0) ? ST_ACK : ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (asm_done) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            imem_wr   = (cmd_q == CMD_LOAD_I);
            data_wr   = (cmd_q == CMD_LOAD_D);
            state_nxt = (cnt_q == 16'd1) ? ST_ACK : ST_PAYLOAD;
         end
         ST_ACK: begin
            tx_valid = 1'b1;
            tx_data  = cmd_q | ACK_FLAG;
            if (tx_ready) state_nxt = ST_CMD;
         end
         ST_RD_WAIT: begin
            state_nxt = ST_RD_LATCH;
         end
         ST_RD_LATCH: begin
            state_nxt = ST_TX;
         end
         ST_TX: begin
            tx_valid = 1'b1;
            tx_data  = rd_word_q[7:0];
            if (tx_ready && (tx_left_q == 2'd0)) state_nxt = ST_CMD;
         end
         ST_HALT_WAIT: begin
            if (!busy) state_nxt = ST_ACK;
         end
         default: begin
            state_nxt = ST_CMD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q     <= 8'h00;
         addr_q    <= '0;
         cnt_q     <= 16'd0;
         rd_word_q <= '0;
         tx_left_q <= 2'd0;
         run_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_CMD: begin
               if (rx_fire) begin
                  if (cmd_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     cmd_q <= rx_data;
                     if (rx_data == CMD_RUN)  run_q <= 1'b1;
                     if (rx_data == CMD_HALT) run_q <= 1'b0;
                  end
               end
            end
            ST_ADDR_LO: if (rx_fire) addr_q[7:0]                 <= rx_data;
            ST_ADDR_HI: if (rx_fire) addr_q[DATA_ADDR_WIDTH-1:8] <= rx_data;
            ST_CNT_LO:  if (rx_fire) cnt_q[7:0]                  <= rx_data;
            ST_CNT_HI:  if (rx_fire) cnt_q[15:8]                 <= rx_data;
            ST_WRITE: begin
               addr_q <= addr_q + 1'b1;
               cnt_q  <= cnt_q - 16'd1;
            end
            ST_RD_LATCH: begin
               rd_word_q <= data_dout;
               tx_left_q <= 2'd3;
            end
            ST_TX: begin
               if (tx_ready) begin
                  rd_word_q <= rd_word_q >> 8;
                  tx_left_q <= tx_left_q - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_addr = addr_q;
   assign imem_data = asm_word;
   assign data_addr = addr_q;
   assign data_din  = asm_word;
   assign run       = run_q;
   assign err       = err_q;

endmodule
